// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg: shared definitions for the text buffer writer and the VGA text
// pixel stage (geometry, character type, control codes, buffer FSM states).
// No ports. Optional feature macro used by importers: TEXT_SCROLL_EN.
// -----------------------------------------------------------------------------
package text_pkg;

    localparam int unsigned COLS     = 64;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned CELLS    = COLS * ROWS;   // 256
    localparam int unsigned COL_BITS = 6;             // log2(COLS)
    localparam int unsigned CH_W     = 8;

    typedef logic [CH_W-1:0] char_t;

    localparam char_t CHAR_SPACE = 8'h20;
    localparam char_t CHAR_LF    = 8'h0A;
    localparam char_t CHAR_CR    = 8'h0D;
    localparam char_t CHAR_BS    = 8'h08;
    localparam char_t CHAR_TILDE = 8'h7E;

    localparam logic [7:0] LAST_CELL      = 8'(CELLS - 1);
    localparam logic [7:0] LAST_ROW_START = 8'(CELLS - COLS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } buf_state_t;

    function automatic logic isPrintable(input char_t c);
        return (c >= CHAR_SPACE) && (c <= CHAR_TILDE);
    endfunction

endpackage

// File: rtl/text_cursor_next.sv
// -----------------------------------------------------------------------------
// text_cursor_next: combinational terminal decode of one byte.
// Ports:
//   cursor     in   current write cell index
//   charIn     in   byte being consumed
//   nextCursor out  cursor after this byte
//   wrEn       out  a cell must be written
//   wrAddr     out  cell to write
//   wrData     out  value to write
//   scrollReq  out  byte pushes past the last row (only with TEXT_SCROLL_EN)
// Macro TEXT_SCROLL_EN: when undefined, overflow wraps the cursor to 0.
// -----------------------------------------------------------------------------
module text_cursor_next
    import text_pkg::*;
(
    input  logic [7:0] cursor,
    input  char_t      charIn,
    output logic [7:0] nextCursor,
    output logic       wrEn,
    output logic [7:0] wrAddr,
    output char_t      wrData,
    output logic       scrollReq
);

    logic [1:0] row;
    assign row = cursor[7:COL_BITS];

    always_comb begin
        nextCursor = cursor;
        wrEn       = 1'b0;
        wrAddr     = cursor;
        wrData     = charIn;
        scrollReq  = 1'b0;

        if (isPrintable(charIn)) begin
            wrEn = 1'b1;
            if (cursor == LAST_CELL) begin
`ifdef TEXT_SCROLL_EN
                scrollReq  = 1'b1;
                nextCursor = LAST_ROW_START;
`else
                nextCursor = 8'd0;
`endif
            end else begin
                nextCursor = cursor + 8'd1;
            end
        end else begin
            case (charIn)
                CHAR_LF: begin
                    if (row == 2'd3) begin
`ifdef TEXT_SCROLL_EN
                        scrollReq  = 1'b1;
                        nextCursor = LAST_ROW_START;
`else
                        nextCursor = 8'd0;
`endif
                    end else begin
                        nextCursor = {row + 2'd1, {COL_BITS{1'b0}}};
                    end
                end
                CHAR_CR: nextCursor = {row, {COL_BITS{1'b0}}};
                CHAR_BS: begin
                    // Backspace blanks the cell it steps back onto.
                    if (cursor != 8'd0) begin
                        nextCursor = cursor - 8'd1;
                        wrEn       = 1'b1;
                        wrAddr     = cursor - 8'd1;
                        wrData     = CHAR_SPACE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// text_buffer_ctrl: terminal-style writer for the 4x64 text array read by the
// VGA text pixel stage. Clear and scroll walk the array one cell per clock.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   char_valid   byte on char_data is offered
//   char_data    ASCII byte
//   char_ready   byte accepted this cycle (IDLE and no clear request)
//   clear_req    one-cycle whole-screen clear request (ignored while busy)
//   text         character array, index = row*COLS + col
//   cursor_pos   next write cell
//   busy         clear or scroll in progress
// Macro TEXT_SCROLL_EN: enables the SCROLL state; without it the cursor wraps.
// -----------------------------------------------------------------------------
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  char_t      char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output char_t      text [CELLS-1:0],
    output logic [7:0] cursor_pos,
    output logic       busy
);

    buf_state_t stateQ;
    logic [7:0] cursorQ;
    logic [7:0] idxQ;
    char_t      textQ [CELLS-1:0];

    logic       accept;
    logic [7:0] nextCursor;
    logic       wrEn;
    logic [7:0] wrAddr;
    char_t      wrData;
    logic       scrollReq;

    text_cursor_next uCursorNext (
        .cursor     (cursorQ),
        .charIn     (char_data),
        .nextCursor (nextCursor),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .scrollReq  (scrollReq)
    );

    // A clear request takes priority over a byte offered in the same cycle.
    assign char_ready = (stateQ == IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;
    assign busy       = (stateQ != IDLE);
    assign cursor_pos = cursorQ;
    assign text       = textQ;

`ifndef TEXT_SCROLL_EN
    logic unusedScroll;
    assign unusedScroll = scrollReq;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                textQ[i] <= CHAR_SPACE;
            end
            cursorQ <= 8'd0;
            idxQ    <= 8'd0;
            stateQ  <= IDLE;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (clear_req) begin
                        stateQ <= CLEAR;
                        idxQ   <= 8'd0;
                    end else if (accept) begin
                        if (wrEn) begin
                            textQ[wrAddr] <= wrData;
                        end
                        cursorQ <= nextCursor;
`ifdef TEXT_SCROLL_EN
                        if (scrollReq) begin
                            stateQ <= SCROLL;
                            idxQ   <= 8'd0;
                        end
`endif
                    end
                end
                CLEAR: begin
                    textQ[idxQ] <= CHAR_SPACE;
                    if (idxQ == LAST_CELL) begin
                        stateQ  <= IDLE;
                        cursorQ <= 8'd0;
                        idxQ    <= 8'd0;
                    end else begin
                        idxQ <= idxQ + 8'd1;
                    end
                end
`ifdef TEXT_SCROLL_EN
                SCROLL: begin
                    // Ascending walk: source idx+64 is still unmodified when read.
                    if (idxQ < LAST_ROW_START) begin
                        textQ[idxQ] <= textQ[idxQ + 8'(COLS)];
                    end else begin
                        textQ[idxQ] <= CHAR_SPACE;
                    end
                    if (idxQ == LAST_CELL) begin
                        stateQ <= IDLE;
                        idxQ   <= 8'd0;
                    end else begin
                        idxQ <= idxQ + 8'd1;
                    end
                end
`endif
                default: stateQ <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_text_buffer_ctrl: self-checking bench for text_buffer_ctrl. A terminal
// model (array + cursor + remaining-operation counter) is compared against the
// DUT every cycle; directed sequences pin the model with literal values.
// Honours TEXT_SCROLL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_text_buffer_ctrl;

`ifdef TEXT_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic [7:0] text [255:0];
    logic [7:0] cursor_pos;
    logic       busy;

    text_buffer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .text       (text),
        .cursor_pos (cursor_pos),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int busyTotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mText [256];
    int mCur;
    int mMode;   // 0 idle, 1 clearing, 2 scrolling
    int mK;      // cells already processed by the running operation

    task automatic overflowRow();
        if (SCROLL_EN) begin
            mMode = 2;
            mK    = 0;
            mCur  = 192;
        end else begin
            mCur = 0;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        int row;
        row = mCur / 64;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mText[mCur] = b;
            if (mCur == 255) overflowRow();
            else mCur = mCur + 1;
        end else if (b == 8'h0A) begin
            if (row < 3) mCur = (row + 1) * 64;
            else overflowRow();
        end else if (b == 8'h0D) begin
            mCur = row * 64;
        end else if (b == 8'h08) begin
            if (mCur > 0) begin
                mCur = mCur - 1;
                mText[mCur] = 8'h20;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mText[i] = 8'h20;
            mCur  = 0;
            mMode = 0;
            mK    = 0;
        end else if (mMode != 0) begin
            if (mMode == 1 || mK >= 192) mText[mK] = 8'h20;
            else mText[mK] = mText[mK + 64];
            mK = mK + 1;
            if (mK == 256) begin
                if (mMode == 1) mCur = 0;
                mMode = 0;
                mK    = 0;
            end
        end else if (clear_req) begin
            mMode = 1;
            mK    = 0;
        end else if (char_valid) begin
            modelByte(char_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int bad;
        if (busy === 1'b1) busyTotal++;
        check("ready", 32'(char_ready), 32'(mMode == 0 && !clear_req));
        check("busy", 32'(busy), 32'(mMode != 0));
        if (mMode == 0) check("cursor", 32'(cursor_pos), 32'(mCur));
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (bad < 0 && text[i] !== mText[i]) bad = i;
        end
        nChecks++;
        if (bad < 0) nPass++;
        else $display("FAIL text[%0d]: got %0h expected %0h at %0t",
                      bad, text[bad], mText[bad], $time);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        char_valid = 1'b1;
        char_data  = b;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic checkAllSpace(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 256; i++) if (bad < 0 && text[i] !== 8'h20) bad = i;
        nChecks++;
        if (bad < 0) nPass++;
        else $display("FAIL %s: cell %0d got %0h expected 20", name, bad, text[bad]);
    endtask

    task automatic doClear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        waitIdle(400);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int startBusy;
        int r;
        logic [7:0] b;

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clear_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        checkAllSpace("reset_text");
        check("reset_cursor", 32'(cursor_pos), 32'd0);
        check("reset_ready", 32'(char_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // "Hi"
        sendByte(8'h48);
        check("hi_text0", 32'(text[0]), 32'h48);
        check("hi_cursor1", 32'(cursor_pos), 32'd1);
        sendByte(8'h69);
        check("hi_text1", 32'(text[1]), 32'h69);
        check("hi_cursor2", 32'(cursor_pos), 32'd2);

        // Control codes from cursor 5
        sendByte(8'h61); sendByte(8'h62); sendByte(8'h63);
        check("cursor5", 32'(cursor_pos), 32'd5);
        sendByte(8'h0A);
        check("lf_cursor", 32'(cursor_pos), 32'd64);
        sendByte(8'h41);
        check("lf_text64", 32'(text[64]), 32'h41);
        check("lf_cursor65", 32'(cursor_pos), 32'd65);
        sendByte(8'h0D);
        check("cr_cursor", 32'(cursor_pos), 32'd64);
        sendByte(8'h08);
        check("bs_cursor", 32'(cursor_pos), 32'd63);
        check("bs_text63", 32'(text[63]), 32'h20);

        // Clear wins over a simultaneous byte; second request during clear ignored
        char_valid = 1'b1;
        char_data  = 8'h41;
        clear_req  = 1'b1;
        tick();
        char_valid = 1'b0;
        clear_req  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            clear_req = (n == 10);
            tick();
            n++;
        end
        clear_req = 1'b0;
        check("clear_cycles", 32'(n), 32'd256);
        checkAllSpace("clear_text");
        check("clear_cursor", 32'(cursor_pos), 32'd0);

        // Fill cells 0..254 with a pattern, walk cursor to 200, then LF
        for (int i = 0; i < 255; i++) sendByte(8'((i % 95) + 32));
        sendByte(8'h0D);
        for (int i = 192; i < 200; i++) sendByte(8'((i % 95) + 32));
        check("fill_cursor200", 32'(cursor_pos), 32'd200);
        sendByte(8'h0A);
        char_valid = 1'b1;   // held through the scroll; must not be consumed
        char_data  = 8'h41;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        char_valid = 1'b0;
        if (SCROLL_EN) begin
            check("scroll_cycles", 32'(n), 32'd256);
            check("scroll_text0", 32'(text[0]), 32'h60);
            check("scroll_text100", 32'(text[100]), 32'h65);
            check("scroll_text190", 32'(text[190]), 32'h60);
            check("scroll_text191", 32'(text[191]), 32'h20);
            check("scroll_text200", 32'(text[200]), 32'h20);
            check("scroll_cursor", 32'(cursor_pos), 32'd192);
        end else begin
            check("wrap_lf_cycles", 32'(n), 32'd0);
            check("wrap_lf_text0", 32'(text[0]), 32'h20);
            check("wrap_lf_text200", 32'(text[200]), 32'h2A);
            check("wrap_lf_cursor", 32'(cursor_pos), 32'd0);
        end
        tick();

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10 || r == 15) b = 8'($urandom_range(32, 126));
            else if (r == 10) b = 8'h0A;
            else if (r == 11) b = 8'h0D;
            else if (r < 14) b = 8'h08;
            else if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 31));
            else b = 8'($urandom_range(127, 255));
            char_data  = b;
            char_valid = ($urandom_range(0, 3) != 0);
            clear_req  = ($urandom_range(0, 499) == 0);
            tick();
        end
        char_valid = 1'b0;
        clear_req  = 1'b0;
        waitIdle(400);

        doClear();
        if (SCROLL_EN) begin
            // Reset in the middle of a scroll
            sendByte(8'h0A); sendByte(8'h0A); sendByte(8'h0A);
            sendByte(8'h0A);
            repeat (99) tick();
            check("midscroll_busy", 32'(busy), 32'd1);
            rst_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_cursor", 32'(cursor_pos), 32'd0);
            check("rst_ready", 32'(char_ready), 32'd1);
            checkAllSpace("rst_text");
            tick();
            rst_n = 1'b1;
            tick();
        end else begin
            // Printable at cursor 255 wraps without going busy
            sendByte(8'h0A); sendByte(8'h0A); sendByte(8'h0A);
            for (int i = 0; i < 63; i++) sendByte(8'h78);
            check("cursor255", 32'(cursor_pos), 32'd255);
            startBusy = busyTotal;
            sendByte(8'h41);
            tick();
            check("wrap_text255", 32'(text[255]), 32'h41);
            check("wrap_cursor", 32'(cursor_pos), 32'd0);
            check("wrap_no_busy", 32'(busyTotal - startBusy), 32'd0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
